// File: rtl/ray_pkg.sv
// ray_pkg: shared types and helpers for the ray direction generator.
//   fp88_t   : signed 8.8 fixed-point value
//   FP_FRAC  : fraction bits of fp88_t
//   CAM_FRAC : fraction bits of cameraX (signed Q2.16)
//   state_t  : sweep FSM states
//   sat16    : clamp a 17-bit signed sum into the fp88_t range
package ray_pkg;

    typedef logic signed [15:0] fp88_t;

    localparam int FP_FRAC  = 8;
    localparam int CAM_FRAC = 16;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

    // A 17-bit sum overflowed 16 bits exactly when its top two bits differ;
    // the top bit then tells which rail to pin to.
    function automatic fp88_t sat16(input logic signed [16:0] v);
        if (v[16] != v[15])
            return v[16] ? 16'sh8000 : 16'sh7FFF;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/fp_mult.sv
// fp_mult: registered signed 16x18 multiply, result scaled back to 8.8.
//   clk_in  : clock
//   rst_in  : async active-low reset
//   en_in   : pipeline advance; the product register holds when low
//   a_in    : signed 8.8 operand (plane component)
//   b_in    : signed Q2.16 operand (cameraX)
//   p_out   : floor((a*b) >> 16), truncated to signed 8.8
module fp_mult
    import ray_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               en_in,
    input  logic signed [15:0] a_in,
    input  logic signed [17:0] b_in,
    output logic signed [15:0] p_out
);

    logic signed [33:0] prod;
    logic               prod_unused;

    assign prod = a_in * b_in;

    // Taking bits [31:16] of the two's-complement product is the arithmetic
    // shift (floor) followed by truncation to 16 bits.
    assign prod_unused = ^{prod[33:32], prod[CAM_FRAC-1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            p_out <= '0;
        else if (en_in)
            p_out <= prod[CAM_FRAC +: 16];
    end

endmodule

// File: rtl/ray_dir_gen.sv
// ray_dir_gen: per-column ray direction generator.
// On frame_start_in (in IDLE) the player pose is snapshotted; then one beat
// per screen column is streamed: rayDir = dir + plane * cameraX, with
// cameraX sweeping -1 .. +1 in CAM_STEP increments.
// Pipeline: issue counter -> S1 (col, cam) -> S2 (plane*cam) -> S3 (add, out).
// All stages advance together on en = ~ray_valid_out | ray_ready_in.
// Ports:
//   clk_in, rst_in (async active-low), frame_start_in (1-cycle pulse)
//   posX_in/posY_in (unsigned 8.8), dirX_in/dirY_in, planeX_in/planeY_in
//   ray_valid_out / ray_ready_in handshake, ray_col_out, ray_last_out
//   rayDirX_out/rayDirY_out (signed 8.8), rayPosX_out/rayPosY_out
//   busy_out (sweep in progress), overrun_out (sticky dropped frame_start)
// Build option: define RAY_DIR_SAT_EN to saturate the stage-3 sum instead
// of wrapping it.
module ray_dir_gen
    import ray_pkg::*;
#(
    parameter int SCREEN_WIDTH = 320,
    parameter int COL_W        = $clog2(SCREEN_WIDTH),
    parameter int CAM_STEP     = (2 * 65536 + SCREEN_WIDTH / 2) / SCREEN_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_start_in,
    input  logic [15:0]      posX_in,
    input  logic [15:0]      posY_in,
    input  logic [15:0]      dirX_in,
    input  logic [15:0]      dirY_in,
    input  logic [15:0]      planeX_in,
    input  logic [15:0]      planeY_in,
    output logic             ray_valid_out,
    input  logic             ray_ready_in,
    output logic [COL_W-1:0] ray_col_out,
    output logic             ray_last_out,
    output logic [15:0]      rayDirX_out,
    output logic [15:0]      rayDirY_out,
    output logic [15:0]      rayPosX_out,
    output logic [15:0]      rayPosY_out,
    output logic             busy_out,
    output logic             overrun_out
);

    localparam int              STAGES   = 3;
    localparam int              NUM_AX   = 2;   // 0 = X, 1 = Y
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);
    localparam logic signed [17:0] CAM_START = -18'sd65536;
    localparam logic signed [17:0] CAM_INC   = 18'(CAM_STEP);

    state_t state_q, state_d;

    logic [NUM_AX-1:0][15:0] pos_q, dir_q, plane_q;
    logic [COL_W-1:0]        col_q;
    logic signed [17:0]      cam_q;

    logic [STAGES:1]         vld_pipe;
    logic                    issue;
    logic                    en;

    logic [COL_W-1:0]        s1_col, s2_col;
    logic signed [17:0]      s1_cam;
    logic [NUM_AX-1:0][15:0] s2_prod;
    logic [NUM_AX-1:0][16:0] sum;
    logic [NUM_AX-1:0][15:0] dir_red;
    logic [NUM_AX-1:0][15:0] out_dir;
    logic [COL_W-1:0]        out_col;
    logic                    out_last;

    assign en    = ~vld_pipe[STAGES] | ray_ready_in;
    assign issue = (state_q == SWEEP);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start_in) state_d = SWEEP;
            SWEEP:   if (en && col_q == LAST_COL) state_d = DRAIN;
            DRAIN:   if (vld_pipe[STAGES] && ray_ready_in && out_last)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- snapshot, issue counter, overrun ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pos_q       <= '0;
            dir_q       <= '0;
            plane_q     <= '0;
            col_q       <= '0;
            cam_q       <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (state_q == IDLE && frame_start_in) begin
                pos_q   <= {posY_in,   posX_in};
                dir_q   <= {dirY_in,   dirX_in};
                plane_q <= {planeY_in, planeX_in};
                col_q   <= '0;
                cam_q   <= CAM_START;
            end else if (issue && en) begin
                col_q <= col_q + 1'b1;
                cam_q <= cam_q + CAM_INC;
            end
            // A pulse outside IDLE is dropped; the running sweep is untouched.
            if (frame_start_in && state_q != IDLE)
                overrun_out <= 1'b1;
        end
    end

    // ---------------- pipeline ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_pipe <= '0;
            s1_col   <= '0;
            s1_cam   <= '0;
            s2_col   <= '0;
            out_col  <= '0;
            out_last <= 1'b0;
            out_dir  <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            s1_col   <= col_q;
            s1_cam   <= cam_q;
            s2_col   <= s1_col;
            out_col  <= s2_col;
            out_last <= vld_pipe[2] && (s2_col == LAST_COL);
            out_dir  <= dir_red;
        end
    end

    genvar a;
    generate
        for (a = 0; a < NUM_AX; a++) begin : g_axis
            fp_mult u_mult (
                .clk_in (clk_in),
                .rst_in (rst_in),
                .en_in  (en),
                .a_in   (plane_q[a]),
                .b_in   (s1_cam),
                .p_out  (s2_prod[a])
            );

            assign sum[a] = {dir_q[a][15], dir_q[a]} + {s2_prod[a][15], s2_prod[a]};
`ifdef RAY_DIR_SAT_EN
            assign dir_red[a] = sat16($signed(sum[a]));
`else
            logic sum_unused;
            assign sum_unused = sum[a][16];
            assign dir_red[a] = sum[a][15:0];
`endif
        end
    endgenerate

    // ---------------- outputs ----------------
    assign ray_valid_out = vld_pipe[STAGES];
    assign ray_col_out   = out_col;
    assign ray_last_out  = out_last;
    assign rayDirX_out   = out_dir[0];
    assign rayDirY_out   = out_dir[1];
    assign rayPosX_out   = pos_q[0];
    assign rayPosY_out   = pos_q[1];
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_ray_dir_gen.sv
// tb_ray_dir_gen: directed bench for ray_dir_gen with hand-computed vectors.
module tb_ray_dir_gen;

    localparam int SW    = 320;
    localparam int COL_W = $clog2(SW);
    localparam int MAXB  = 400;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             frame_start_in;
    logic [15:0]      posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in;
    logic             ray_valid_out, ray_ready_in, ray_last_out;
    logic [COL_W-1:0] ray_col_out;
    logic [15:0]      rayDirX_out, rayDirY_out, rayPosX_out, rayPosY_out;
    logic             busy_out, overrun_out;

    ray_dir_gen #(.SCREEN_WIDTH(SW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .posX_in        (posX_in),
        .posY_in        (posY_in),
        .dirX_in        (dirX_in),
        .dirY_in        (dirY_in),
        .planeX_in      (planeX_in),
        .planeY_in      (planeY_in),
        .ray_valid_out  (ray_valid_out),
        .ray_ready_in   (ray_ready_in),
        .ray_col_out    (ray_col_out),
        .ray_last_out   (ray_last_out),
        .rayDirX_out    (rayDirX_out),
        .rayDirY_out    (rayDirY_out),
        .rayPosX_out    (rayPosX_out),
        .rayPosY_out    (rayPosY_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // captured beats of the current sweep
    int          nb;
    int          b_col [MAXB];
    int          b_cyc [MAXB];
    logic        b_last[MAXB];
    logic [15:0] b_dx  [MAXB], b_dy[MAXB], b_px[MAXB], b_py[MAXB];
    int          first_cyc, end_cyc, stable_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_pose(input logic [15:0] px, py, dx, dy, plx, ply);
        posX_in = px;  posY_in = py;
        dirX_in = dx;  dirY_in = dy;
        planeX_in = plx; planeY_in = ply;
    endtask

    // Leaves us just after the sampling edge E.
    task automatic start_frame();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    // Expected 8.8 ray component for a column, from the arithmetic definition.
    function automatic logic [15:0] ref_dir(input logic [15:0] d, input logic [15:0] p,
                                            input int col);
        longint      cam, prod, sh, s;
        logic [63:0] shv;
        logic signed [15:0] p16;
        cam  = -65536 + longint'(col) * 410;
        prod = longint'($signed(p)) * cam;
        sh   = prod >>> 16;
        shv  = sh;
        p16  = shv[15:0];
        s    = longint'($signed(d)) + longint'(p16);
`ifdef RAY_DIR_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        shv = s;
        return shv[15:0];
    endfunction

    // Run a whole sweep starting right after edge E, recording handshakes.
    task automatic sweep(input int stall_col, input bit wiggle, input int fs_col);
        int          cyc;
        bit          stalled;
        logic [31:0] hc, hx, hy;
        nb = 0; cyc = 0; stalled = 0;
        first_cyc = -1; end_cyc = -1; stable_err = 0;
        while (cyc < 2000) begin
            frame_start_in = 1'b0;
            if (ray_valid_out) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (!stalled && stall_col >= 0 && int'(ray_col_out) == stall_col) begin
                    stalled = 1;
                    ray_ready_in = 1'b0;
                    hc = 32'(ray_col_out); hx = 32'(rayDirX_out); hy = 32'(rayDirY_out);
                    for (int k = 0; k < 10; k++) begin
                        tick(); cyc++;
                        if (!ray_valid_out || 32'(ray_col_out) != hc ||
                            32'(rayDirX_out) != hx || 32'(rayDirY_out) != hy)
                            stable_err++;
                    end
                    ray_ready_in = 1'b1;
                end
                if (nb < MAXB) begin
                    b_col[nb] = int'(ray_col_out); b_cyc[nb] = cyc;
                    b_last[nb] = ray_last_out;
                    b_dx[nb] = rayDirX_out; b_dy[nb] = rayDirY_out;
                    b_px[nb] = rayPosX_out; b_py[nb] = rayPosY_out;
                end
                nb++;
                if (fs_col >= 0 && int'(ray_col_out) == fs_col) frame_start_in = 1'b1;
            end
            if (wiggle)
                set_pose(16'($urandom), 16'($urandom), 16'($urandom),
                         16'($urandom), 16'($urandom), 16'($urandom));
            tick(); cyc++;
            if (!busy_out) begin
                end_cyc = cyc;
                break;
            end
        end
        frame_start_in = 1'b0;
        chk("sweep_terminates", 32'(end_cyc >= 0), 32'd1);
    endtask

    // Per-beat consistency against a pose; returns error count.
    function automatic int beat_errs(input logic [15:0] px, py, dx, dy, plx, ply);
        int e = 0;
        for (int i = 0; i < SW && i < nb; i++) begin
            if (b_col[i] != i) e++;
            if (b_last[i] != (i == SW - 1)) e++;
            if (b_px[i] != px || b_py[i] != py) e++;
            if (b_dx[i] != ref_dir(dx, plx, i)) e++;
            if (b_dy[i] != ref_dir(dy, ply, i)) e++;
        end
        return e;
    endfunction

    initial begin
        rst_in = 1'b0;
        frame_start_in = 1'b0;
        ray_ready_in = 1'b1;
        set_pose(16'h1234, 16'h5678, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        #1;
        chk("rst_valid",   32'(ray_valid_out), 32'd0);
        chk("rst_busy",    32'(busy_out),      32'd0);
        chk("rst_overrun", 32'(overrun_out),   32'd0);
        chk("rst_pos",     {rayPosX_out, rayPosY_out}, 32'd0);
        chk("rst_dir",     {rayDirX_out, rayDirY_out}, 32'd0);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();

        // ---- frame 1: basic sweep, timing, spot values ----
        start_frame();
        sweep(-1, 0, -1);
        chk("f1_latency",  32'(first_cyc), 32'd3);
        chk("f1_busyfall", 32'(end_cyc),   32'(SW + 3));
        chk("f1_nbeats",   32'(nb),        32'(SW));
        chk("f1_c0",       {b_dx[0], b_dy[0]},     {16'hFF00, 16'hFF57});
        chk("f1_c160",     {b_dx[160], b_dy[160]}, {16'hFF00, 16'h0000});
        chk("f1_c319",     {b_dx[319], b_dy[319]}, {16'hFF00, 16'h00A8});
        chk("f1_last319",  32'(b_last[319]), 32'd1);
        chk("f1_pos",      {b_px[77], b_py[77]}, {16'h1234, 16'h5678});
        chk("f1_beats",    32'(beat_errs(16'h1234, 16'h5678, 16'hFF00, 16'h0000,
                                         16'h0000, 16'h00A9)), 32'd0);
        chk("f1_overrun",  32'(overrun_out), 32'd0);

        // ---- frame 2: pose wiggles every cycle, stall on col 5 ----
        set_pose(16'h0A0B, 16'h0C0D, 16'h0123, 16'hFE80, 16'hFFA0, 16'h0054);
        tick();
        start_frame();
        sweep(5, 1, -1);
        chk("f2_nbeats",   32'(nb), 32'(SW));
        chk("f2_stable",   32'(stable_err), 32'd0);
        chk("f2_c6_next",  32'(b_cyc[6] - b_cyc[5]), 32'd1);
        chk("f2_beats",    32'(beat_errs(16'h0A0B, 16'h0C0D, 16'h0123, 16'hFE80,
                                         16'hFFA0, 16'h0054)), 32'd0);

        // ---- frame 3: overflow corner + dropped frame_start at col 100 ----
        set_pose(16'h0101, 16'h0202, 16'h7F00, 16'h0000, 16'h7FFF, 16'h0000);
        tick();
        start_frame();
        sweep(-1, 0, 100);
        chk("f3_nbeats",   32'(nb), 32'(SW));
        chk("f3_c0",       32'(b_dx[0]), 32'hFF01);
`ifdef RAY_DIR_SAT_EN
        chk("f3_c319_sat", 32'(b_dx[319]), 32'h7FFF);
`else
        chk("f3_c319_wrap", 32'(b_dx[319]), 32'hFE72);
`endif
        chk("f3_beats",    32'(beat_errs(16'h0101, 16'h0202, 16'h7F00, 16'h0000,
                                         16'h7FFF, 16'h0000)), 32'd0);
        chk("f3_overrun",  32'(overrun_out), 32'd1);

        // ---- frame 4: next IDLE frame_start still accepted ----
        set_pose(16'h0303, 16'h0404, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        start_frame();
        sweep(-1, 0, -1);
        chk("f4_latency",  32'(first_cyc), 32'd3);
        chk("f4_nbeats",   32'(nb), 32'(SW));
        chk("f4_overrun",  32'(overrun_out), 32'd1);

        // ---- reset mid-sweep at col 50 ----
        start_frame();
        for (int i = 0; i < 400; i++) begin
            if (ray_valid_out && int'(ray_col_out) == 50) break;
            tick();
        end
        chk("r_reached50", 32'(ray_valid_out && int'(ray_col_out) == 50), 32'd1);
        #2 rst_in = 1'b0;
        #1;
        chk("r_valid",   32'(ray_valid_out), 32'd0);
        chk("r_busy",    32'(busy_out),      32'd0);
        chk("r_overrun", 32'(overrun_out),   32'd0);
        chk("r_outs",    {rayDirX_out, rayDirY_out}, 32'd0);
        chk("r_pos_col", {rayPosX_out, 7'd0, ray_col_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        start_frame();
        tick(); tick();
        chk("r_pre_valid", 32'(ray_valid_out), 32'd0);
        tick();
        chk("r_first",     {31'(ray_col_out), ray_valid_out}, 32'd1);
        chk("r_first_dir", {rayDirX_out, rayDirY_out}, {16'hFF00, 16'hFF57});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_dir_gen.md
# ray_dir_gen

Per-column ray direction generator for the raycaster, directly downstream of the player-control path. On each frame start it snapshots the player pose (posX/posY, dirX/dirY, planeX/planeY, signed 8.8 fixed point). It then streams one ray per screen column, rayDir = dir + plane·cameraX with cameraX sweeping −1…+1, to the DDA/wall-hit stage over a valid/ready handshake. The pose stays frozen for the whole sweep, so button moves never tear a frame.

## Interface
- SCREEN_WIDTH, 320: columns per frame (≥2).
- COL_W, $clog2(SCREEN_WIDTH): column index width.
- CAM_STEP, round(2·65536/SCREEN_WIDTH) (410 for 320): cameraX increment, Q.16.

- clk_in  in  1  single clock.
- rst_in  in  1  reset, asynchronous, active-low.
- frame_start_in  in  1  one-cycle pulse, start of frame.
- posX_in, posY_in  in  16  player position, unsigned 8.8.
- dirX_in, dirY_in, planeX_in, planeY_in  in  16  signed 8.8.
- ray_valid_out  out  1  ray beat valid.
- ray_ready_in  in  1  consumer accepts beat.
- ray_col_out  out  COL_W  column index of beat.
- ray_last_out  out  1  beat is column SCREEN_WIDTH−1.
- rayDirX_out, rayDirY_out  out  16  signed 8.8.
- rayPosX_out, rayPosY_out  out  16  snapshotted position, constant across sweep.
- busy_out  out  1  sweep in progress.
- overrun_out  out  1  sticky: frame_start dropped while busy.

## Operation
- FSM: IDLE → SWEEP → DRAIN → IDLE.
- IDLE: frame_start_in high → latch all six pose inputs. Set col=0, cam=−65536 (signed 18-bit Q2.16). Go to SWEEP.
- SWEEP: each enabled cycle issues (col, cam) into the pipeline, then col+1 and cam+CAM_STEP. After issuing col SCREEN_WIDTH−1, go to DRAIN.
- DRAIN: wait for the handshake of the beat with ray_last_out. Then go to IDLE.
- Handshake completes on a cycle with ray_valid_out & ray_ready_in.
- Pipeline enable: en = ~ray_valid_out | ray_ready_in. All stages and the issue counter advance only when en=1.
- Stage 1 registers col and cam.
- Stage 2 computes plane·cam as a 16×18 signed product, arithmetic right shift 16 (floor), giving 8.8.
- Stage 3 computes dir + product in 17 bits, then reduces to 16 bits (see Configuration). It registers the outputs and the valid flag.
- frame_start_in outside IDLE, including the cycle of the last handshake, sets overrun_out. The pulse is dropped and the sweep is unaffected.
- overrun_out clears only on reset.
- busy_out = (state ≠ IDLE).

## Timing
- Reset (rst_in low, async): state IDLE; all outputs 0; overrun_out 0; pipeline valids 0; snapshots 0.
- Reset mid-sweep aborts immediately. No partial beat survives.
- Latency: frame_start_in sampled at edge E → first beat (col 0) valid after edge E+3.
- With ready held high, throughput is 1 beat/cycle. Last beat is valid after edge E+SCREEN_WIDTH+2, and busy_out falls after edge E+SCREEN_WIDTH+3.
- While valid and not ready, all data outputs are held stable. No column is skipped or duplicated.
- ray_col_out increments by exactly 1 per handshake, from 0 to SCREEN_WIDTH−1.

## Configuration
- RAY_DIR_SAT_EN defined: stage-3 sum saturates. Values above 0x7FFF become 0x7FFF; values below 0x8000 become 0x8000.
- RAY_DIR_SAT_EN undefined: two's-complement wrap (low 16 bits of the sum).

## Structure
- Package ray_pkg holds:
  - fp88_t (signed [15:0]), FP_FRAC=8, CAM_FRAC=16.
  - state enum {IDLE, SWEEP, DRAIN}.
  - sat16 function.
- Sub-module fp_mult: registered signed 16×18 multiply with arithmetic shift, instantiated twice (X and Y).
- Top level holds the FSM, issue counter, snapshots, stage-3 add and the handshake.

## Test plan
- dir=(0xFF00,0), plane=(0,0x00A9), ready high, one frame_start:
  - col 0 → rayDir (0xFF00, 0xFF57).
  - col 160 → (0xFF00, 0x0000).
  - col 319 → (0xFF00, 0x00A8), with ray_last_out=1.
- Pose inputs changed every cycle mid-sweep → all 320 beats use the pose sampled at frame_start. rayPos is constant.
- ready low for 10 cycles while col 5 is valid → outputs stable. Col 6 follows on the first cycle after ready returns. Total of 320 unique beats.
- dir=(0x7F00,0), plane=(0x7FFF,0), col 319:
  - with RAY_DIR_SAT_EN → rayDirX 0x7FFF.
  - without → 0xFE72.
- frame_start pulsed at col 100 → overrun_out=1, sweep completes normally, next IDLE frame_start is accepted.
- rst_in low at col 50 → all outputs 0 and busy_out=0 immediately. A new frame_start after release gives col 0 three edges later.
